bus_datapath: RTL and testbench

- Datapath stage directly downstream of the controller. Consumes the controller's one-hot register-output lines (rout), register-enable lines (ren), the ALU select (addxor) and the current instruction byte.
- Contains an 8-entry register file, an ALU operand latch A, and an ALU result register G, all connected by a single muxed shared bus.
- Executes one bus transfer per clock.
- Exposes the bus, flags and a debug read port for bench and board observation.

---
 rtl/bus_datapath.sv | 106 ++++++++++
 tb/tb_bus_datapath.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath.sv
// Purpose : shared-bus datapath with an 8-entry register file, ALU operand latch A and
//           result register G. It executes one bus transfer per clock.
// Latency : bus and ALU paths are combinational. Loads land on the rising edge and show
//           on bus/dbg_data one cycle after the enables.
// Backpr. : none. The controller owns sequencing, and rout/ren are level-sampled each cycle.
//
// Ports   : clock, resetnot (async active-low), instruction[7:0] (bits [3:0] = immediate),
//           rout[15:0] one-hot bus driver select, ren[15:0] load enables, addxor (0 add, 1 xor),
//           dbg_sel/dbg_data debug read of R[dbg_sel], bus, carry, zero, bus_conflict,
//           conflict_err.
// Option  : define DATAPATH_CONFLICT_HOLD_EN to suppress every load on a conflicting cycle
//           and to latch the sticky conflict_err flag.
module bus_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetnot,
  input  logic [7:0]       instruction,
  input  logic [15:0]      rout,
  input  logic [15:0]      ren,
  input  logic             addxor,
  input  logic [2:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] bus,
  output logic             carry,
  output logic             zero,
  output logic             bus_conflict,
  output logic             conflict_err
);

  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] bus_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu;
  logic             alu_carry;
  logic             load_ok;

  // Reserved select/enable bits and the upper opcode bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{rout[15:10], ren[15:10], instruction[7:4]};

  assign imm = WIDTH'(instruction[3:0]);

  // The bus is a pure OR-mux. Several drivers at once give the OR of all of them.
  always_comb begin
    bus_v = '0;
    for (int i = 0; i < 8; i++) begin
      if (rout[i]) bus_v = bus_v | regs[i];
    end
    if (rout[8]) bus_v = bus_v | g_q;
    if (rout[9]) bus_v = bus_v | imm;
  end

  assign bus = bus_v;

  // More than one bit set in rout[9:0]: x & (x-1) clears the lowest set bit.
  assign bus_conflict = ((rout[9:0] & (rout[9:0] - 10'd1)) != 10'd0);

  assign sum       = {1'b0, a_q} + {1'b0, bus_v};
  assign alu       = addxor ? (a_q ^ bus_v) : sum[WIDTH-1:0];
  assign alu_carry = addxor ? 1'b0 : sum[WIDTH];

  assign dbg_data = regs[dbg_sel];

`ifdef DATAPATH_CONFLICT_HOLD_EN
  assign load_ok = !bus_conflict;

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      conflict_err <= 1'b0;
    end else if (bus_conflict) begin
      conflict_err <= 1'b1;
    end
  end
`else
  assign load_ok      = 1'b1;
  assign conflict_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      a_q   <= '0;
      g_q   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (load_ok) begin
      for (int i = 0; i < 8; i++) begin
        // A register that drives the bus while loading keeps its old value. This also
        // holds when other sources are OR'd onto the bus in the same cycle.
        if (ren[i] && !rout[i]) regs[i] <= bus_v;
      end
      if (ren[8]) a_q <= bus_v;
      // G and the flags use the pre-edge A, even if A loads on the same edge.
      if (ren[9]) begin
        g_q   <= alu;
        carry <= alu_carry;
        zero  <= (alu == '0);
      end
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
module tb_bus_datapath;

  logic        clock;
  logic        resetnot;
  logic [7:0]  instruction;
  logic [15:0] rout;
  logic [15:0] ren;
  logic        addxor;
  logic [2:0]  dbg_sel;

  logic [7:0]  dbg8, bus8;
  logic        carry8, zero8, conf8, err8;
  logic [3:0]  dbg4, bus4;
  logic        carry4, zero4, conf4, err4;

  int n_checks = 0;
  int n_fail   = 0;

  bus_datapath #(.WIDTH(8)) u8 (
    .clock(clock), .resetnot(resetnot), .instruction(instruction), .rout(rout), .ren(ren),
    .addxor(addxor), .dbg_sel(dbg_sel), .dbg_data(dbg8), .bus(bus8), .carry(carry8),
    .zero(zero8), .bus_conflict(conf8), .conflict_err(err8)
  );

  bus_datapath #(.WIDTH(4)) u4 (
    .clock(clock), .resetnot(resetnot), .instruction(instruction), .rout(rout), .ren(ren),
    .addxor(addxor), .dbg_sel(dbg_sel), .dbg_data(dbg4), .bus(bus4), .carry(carry4),
    .zero(zero4), .bus_conflict(conf4), .conflict_err(err4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1ns so that outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] ro, input logic [15:0] re,
                       input logic [7:0] ins, input logic op);
    rout = ro; ren = re; instruction = ins; addxor = op;
  endtask

  task automatic idle();
    drive(16'h0, 16'h0, 8'h00, 1'b0);
  endtask

  // Load an immediate into R_idx with one transfer.
  task automatic load_imm(input int idx, input logic [3:0] val);
    drive(16'h0200, 16'(1) << idx, {4'h0, val}, 1'b0);
    step();
    idle();
  endtask

  task automatic test_reset();
    load_imm(0, 4'h5);
    load_imm(4, 4'h9);
    drive(16'h0200, 16'h0200, 8'h0F, 1'b0);  // G is nonzero, and the flags get written
    step();
    @(negedge clock);
    #2;
    resetnot = 1'b0;                          // mid-cycle, with no edge before the checks
    idle();
    #1;
    for (int s = 0; s < 8; s++) begin
      dbg_sel = 3'(s);
      #1;
      n_checks++;
      if (dbg8 !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dbg sel=%0d got=%h exp=00", s, dbg8);
      end
    end
    n_checks++;
    if (carry8 !== 1'b0 || zero8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got c=%b z=%b exp c=0 z=0", carry8, zero8);
    end
    n_checks++;
    if (bus8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus got=%h exp=00", bus8);
    end
    rout = 16'h0100;                          // G must also have cleared
    #1;
    n_checks++;
    if (bus8 !== 8'h00 || err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_g got g=%h err=%b exp g=00 err=0", bus8, err8);
    end
    idle();
    @(negedge clock);
    resetnot = 1'b1;
    #1;
  endtask

  task automatic test_imm_load();
    drive(16'h0200, 16'h0001, 8'h05, 1'b0);
    #1;
    n_checks++;
    if (bus8 !== 8'h05 || conf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL imm_bus got=%h conf=%b exp=05 conf=0", bus8, conf8);
    end
    step();
    idle();
    dbg_sel = 3'd0;
    #1;
    n_checks++;
    if (dbg8 !== 8'h05) begin
      n_fail++;
      $display("FAIL imm_r0 got=%h exp=05", dbg8);
    end
  endtask

  task automatic test_add_xor();
    load_imm(0, 4'h5);
    load_imm(1, 4'h3);
    drive(16'h0001, 16'h0100, 8'h00, 1'b0); step();   // A = R0 = 5
    drive(16'h0002, 16'h0200, 8'h00, 1'b0); step();   // G = 5 + 3
    n_checks++;
    if (carry8 !== 1'b0 || zero8 !== 1'b0) begin
      n_fail++;
      $display("FAIL add_flags got c=%b z=%b exp c=0 z=0", carry8, zero8);
    end
    drive(16'h0100, 16'h0004, 8'h00, 1'b0);           // R2 = G
    #1;
    n_checks++;
    if (bus8 !== 8'h08) begin
      n_fail++;
      $display("FAIL add_g_bus got=%h exp=08", bus8);
    end
    step();
    idle();
    dbg_sel = 3'd2;
    #1;
    n_checks++;
    if (dbg8 !== 8'h08) begin
      n_fail++;
      $display("FAIL add_r2 got=%h exp=08", dbg8);
    end
    drive(16'h0001, 16'h0100, 8'h00, 1'b0); step();   // A = 5
    drive(16'h0002, 16'h0200, 8'h00, 1'b1); step();   // G = 5 ^ 3
    drive(16'h0100, 16'h0000, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus8 !== 8'h06 || carry8 !== 1'b0 || zero8 !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_g got g=%h c=%b z=%b exp g=06 c=0 z=0", bus8, carry8, zero8);
    end
    idle();
  endtask

  task automatic test_carry_w4();
    drive(16'h0200, 16'h0100, 8'h0F, 1'b0); step();   // A = F
    drive(16'h0200, 16'h0200, 8'h01, 1'b0); step();   // G = F + 1
    drive(16'h0100, 16'h0000, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus4 !== 4'h0 || carry4 !== 1'b1 || zero4 !== 1'b1) begin
      n_fail++;
      $display("FAIL w4_add got g=%h c=%b z=%b exp g=0 c=1 z=1", bus4, carry4, zero4);
    end
    drive(16'h0200, 16'h0100, 8'h00, 1'b0); step();   // A = 0, and the flags must hold
    n_checks++;
    if (carry4 !== 1'b1 || zero4 !== 1'b1) begin
      n_fail++;
      $display("FAIL w4_hold got c=%b z=%b exp c=1 z=1", carry4, zero4);
    end
    drive(16'h0200, 16'h0200, 8'h00, 1'b1); step();   // G = 0 ^ 0
    n_checks++;
    if (carry4 !== 1'b0 || zero4 !== 1'b1) begin
      n_fail++;
      $display("FAIL w4_xor got c=%b z=%b exp c=0 z=1", carry4, zero4);
    end
    idle();
  endtask

  task automatic test_conflict();
    logic [7:0] exp_r3;
    logic       exp_err;
`ifdef DATAPATH_CONFLICT_HOLD_EN
    exp_r3  = 8'h09;
    exp_err = 1'b1;
`else
    exp_r3  = 8'h05;
    exp_err = 1'b0;
`endif
    load_imm(0, 4'h4);
    load_imm(1, 4'h1);
    load_imm(3, 4'h9);
    n_checks++;
    if (err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL conf_err_pre got=%b exp=0", err8);
    end
    drive(16'h0003, 16'h0008, 8'h00, 1'b0);
    #1;
    n_checks++;
    if (bus8 !== 8'h05 || conf8 !== 1'b1) begin
      n_fail++;
      $display("FAIL conf_bus got=%h conf=%b exp=05 conf=1", bus8, conf8);
    end
    step();
    idle();
    dbg_sel = 3'd3;
    #1;
    n_checks++;
    if (dbg8 !== exp_r3) begin
      n_fail++;
      $display("FAIL conf_r3 got=%h exp=%h", dbg8, exp_r3);
    end
    step();
    n_checks++;
    if (err8 !== exp_err || conf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL conf_err got=%b conf=%b exp=%b conf=0", err8, conf8, exp_err);
    end
  endtask

  task automatic test_self_ref_reset();
    load_imm(2, 4'h7);
    drive(16'h0004, 16'h0004, 8'h00, 1'b0); step();
    idle();
    dbg_sel = 3'd2;
    #1;
    n_checks++;
    if (dbg8 !== 8'h07) begin
      n_fail++;
      $display("FAIL self_ref_r2 got=%h exp=07", dbg8);
    end
    load_imm(0, 4'hA);
    dbg_sel = 3'd0;
    #1;
    n_checks++;
    if (dbg8 !== 8'h0A) begin
      n_fail++;
      $display("FAIL pre_reset_r0 got=%h exp=0a", dbg8);
    end
    drive(16'h0200, 16'h0001, 8'h03, 1'b0);           // a pending load of 3 into R0
    #2;
    resetnot = 1'b0;
    step();
    idle();
    @(negedge clock);
    resetnot = 1'b1;
    #1;
    n_checks++;
    if (dbg8 !== 8'h00 || err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop got r0=%h err=%b exp r0=00 err=0", dbg8, err8);
    end
  endtask

  initial begin
    resetnot = 1'b0;
    dbg_sel  = 3'd0;
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetnot = 1'b1;
    test_reset();
    test_imm_load();
    test_add_xor();
    test_carry_w4();
    test_conflict();
    test_self_ref_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
